// File: rtl/std_spram_rmw.sv
// std_spram_rmw: parametrised single-port SRAM with a valid/ready request port
// and byte-enable writes. Partial writes run as an internal read-modify-write.
// Optional build macro STD_SPRAM_OREG_EN adds an output register stage, which
// makes the read latency 2 cycles.
module std_spram_rmw #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BE_WIDTH   = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  err
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                r_state;
  state_e                w_state_d;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_mem_rdata;

  // Operands of a pending partial write
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [BE_WIDTH-1:0]   r_be;

  // First response stage
  logic                  r_rsp_valid;
  logic                  r_rsp_oor;
  logic                  r_err_rd;
  logic                  r_err_wr;
  logic [WIDTH-1:0]      r_rdata_hold;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_be_all;
  logic                  w_be_none;
  logic                  w_mem_re;
  logic                  w_mem_we;
  logic                  w_latch;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wdata;
  logic [WIDTH-1:0]      w_merged;
  logic [WIDTH-1:0]      w_rsp_rdata1;

  assign req_ready  = (r_state == StIdle);
  assign w_accept   = req_valid & req_ready;
  assign w_in_range = ({1'b0, req_addr} < DepthW);
  assign w_be_all   = &req_be;
  assign w_be_none  = ~|req_be;

  // Merge latched write bytes over the word read back in the previous cycle.
  always_comb begin
    w_merged = r_mem_rdata;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (r_be[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  // FSM next state and array access decode.
  always_comb begin
    w_state_d   = r_state;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    w_latch     = 1'b0;
    w_mem_addr  = req_addr;
    w_mem_wdata = req_wdata;
    case (r_state)
      StIdle: begin
        // Out-of-range requests are accepted but never touch the array.
        if (w_accept && w_in_range) begin
          if (!req_we) begin
            w_mem_re = 1'b1;
          end else if (w_be_all) begin
            w_mem_we = 1'b1;
          end else if (!w_be_none) begin
            w_mem_re  = 1'b1;
            w_latch   = 1'b1;
            w_state_d = StRmwWr;
          end
        end
      end
      StRmwWr: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = w_merged;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state register; async reset drops a pending merged write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Storage array, one access per cycle; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
    if (w_mem_re) begin
      r_mem_rdata <= r_mem[w_mem_addr];
    end
  end

  // Latch operands of a partial write for the merge cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_latch) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // First response stage: read-valid and error pulses one cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_oor   <= 1'b0;
      r_err_rd    <= 1'b0;
      r_err_wr    <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept & ~req_we;
      r_rsp_oor   <= w_accept & ~req_we & ~w_in_range;
      r_err_rd    <= w_accept & ~req_we & ~w_in_range;
      r_err_wr    <= w_accept & req_we & ~w_in_range;
    end
  end

  // Read data shown to the consumer; holds its last value between pulses.
  assign w_rsp_rdata1 = r_rsp_valid ? (r_rsp_oor ? '0 : r_mem_rdata) : r_rdata_hold;

  // Remember the last presented read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_hold <= '0;
    end else begin
      r_rdata_hold <= w_rsp_rdata1;
    end
  end

`ifdef STD_SPRAM_OREG_EN
  logic             r_rsp_valid2;
  logic             r_err_rd2;
  logic [WIDTH-1:0] r_rsp_rdata2;

  // Output register stage; write-side errors bypass it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid2 <= 1'b0;
      r_err_rd2    <= 1'b0;
      r_rsp_rdata2 <= '0;
    end else begin
      r_rsp_valid2 <= r_rsp_valid;
      r_err_rd2    <= r_err_rd;
      r_rsp_rdata2 <= w_rsp_rdata1;
    end
  end

  assign rsp_valid = r_rsp_valid2;
  assign rsp_rdata = r_rsp_rdata2;
  assign err       = r_err_rd2 | r_err_wr;
`else
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = w_rsp_rdata1;
  assign err       = r_err_rd | r_err_wr;
`endif

endmodule

// File: doc/std_spram_rmw.md
Name: std_spram_rmw

Overview:
- Parametrised successor to the fixed-geometry single-port SRAM wrappers. Width and depth are generic, and depth need not be a power of two.
- Adds a valid/ready request port and byte-enable writes. Partial writes are done by an internal read-modify-write (RMW) sequence, because the single-port array has no bit mask.
- Sits between NPU buffer controllers and the single-port storage. Replaces per-size wrappers where byte-granular updates are required.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; 2 <= DEPTH <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 6, address width.
- BE_WIDTH, WIDTH/8, byte-enable width (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  WIDTH  write data.
- req_be  in  BE_WIDTH  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_rdata  out  WIDTH  read data.
- err  out  1  one-cycle pulse: out-of-range access accepted.

Behaviour:
- Storage: single-port array, one access per cycle (read or write), 1-cycle read latency. Contents are not reset.
- FSM states: IDLE, RMW_WR. Reset state is IDLE.
- req_ready = (state == IDLE). req_ready reads 1 while rst is held.
- Reset values: rsp_valid = 0, rsp_rdata = 0, err = 0.
- Read accepted at cycle T:
  - array read issued at T;
  - rsp_valid = 1 and rsp_rdata = word at T+1;
  - back-to-back reads sustain 1 per cycle.
- Write with req_be all ones: array written at T, stays in IDLE, full throughput.
- Write with req_be all zeros: accepted, no array access, no state change.
- Partial write (any other req_be) at T:
  - array read of req_addr at T;
  - addr, wdata and be latched; go to RMW_WR;
  - at T+1: merge (enabled bytes from latched wdata, other bytes from array output), write merged word, req_ready = 0, return to IDLE;
  - next accept at T+2 earliest;
  - rsp_valid stays 0 throughout the RMW.
- Ordering: a read accepted at T+2 after a partial write at T returns the merged value. No forwarding is needed because accesses are serialised.
- Out-of-range (req_addr >= DEPTH):
  - request is accepted with no array access and no RMW;
  - read: rsp_valid pulses at T+1 with rsp_rdata = 0;
  - err pulses at T+1 for reads and writes alike.
- rsp_rdata holds its last value while rsp_valid = 0.
- No response backpressure; the consumer must take data in the rsp_valid cycle.
- Reset during RMW_WR:
  - FSM returns to IDLE immediately;
  - the pending merged write is dropped and the array word keeps its pre-request value;
  - rsp_valid and err are cleared.
- req_* are ignored when req_ready = 0; the source must hold them stable until accepted.

Optional Feature:
- Macro: STD_SPRAM_OREG_EN.
- Defined:
  - an extra output register stage is added;
  - read latency becomes 2 (rsp_valid, rsp_rdata and read-side err at T+2; write-side err stays at T+1);
  - throughput is unchanged;
  - RMW merge still uses the raw array output at T+1, so RMW timing is unchanged;
  - the output stage is reset to 0.
- Undefined: latency is 1 as above.

Test Plan:
- Reset with rst = 1, then release → req_ready = 1, rsp_valid = 0, err = 0, rsp_rdata = 0.
- Full write addr 5 = 16'hA5C3 (be = 2'b11), then read addr 5 → rsp_valid at read T+1, rsp_rdata = 16'hA5C3. Reads at addrs 0..3 back-to-back give 4 consecutive rsp_valid pulses.
- With addr 5 = 16'hA5C3, partial write be = 2'b10, wdata = 16'h7E00, immediate read addr 5:
  - req_ready = 0 for exactly one cycle;
  - rsp_rdata = 16'h7EC3.
- DEPTH = 48: read addr 50 → rsp_valid = 1, rsp_rdata = 0, err = 1 at T+1. Write addr 63 → err = 1 and no array change (addr 63 aliasing check).
- Write with be = 2'b00 to addr 5 → no change, and the next-cycle read returns the prior value.
- Assert rst in the RMW_WR cycle of a partial write to addr 7 (old value 16'h1234) → req_ready = 1 after reset, and a read of addr 7 returns 16'h1234. With STD_SPRAM_OREG_EN defined, repeat the read test → rsp_valid at T+2.
